pipelined_carry_lookahead_adder: RTL and testbench

//   Two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.

---
 rtl/pipelined_carry_lookahead_adder_if.sv | 29 ++
 rtl/pipelined_carry_lookahead_adder.sv | 155 +++++++++++++++
 tb/tb_pipelined_carry_lookahead_adder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_carry_lookahead_adder_if.sv
// Operand/result bus for the pipelined carry-lookahead adder.
// The master drives the operands and out_ready. The slave (the adder) drives in_ready and the results.
interface pipelined_carry_lookahead_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             carry_in;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             carry_out;
  logic             overflow;
  logic             group_generate;
  logic             group_propagate;

  modport master (
    output in_valid, mode, carry_in, x, y, out_ready,
    input  in_ready, out_valid, z, carry_out, overflow, group_generate, group_propagate
  );

  modport slave (
    input  in_valid, mode, carry_in, x, y, out_ready,
    output in_ready, out_valid, z, carry_out, overflow, group_generate, group_propagate
  );
endinterface

// File: rtl/pipelined_carry_lookahead_adder.sv
// Two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.
// Stage 1 registers the bit and group generate/propagate signals.
// Stage 2 resolves the group carries with a second lookahead level, then forms the sum and flags.
module pipelined_carry_lookahead_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  pipelined_carry_lookahead_adder_if.slave bus
);

  localparam int unsigned NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_group_check
    $error("pipelined_carry_lookahead_adder: WIDTH must be a multiple of GROUP");
  end

  logic [WIDTH-1:0] w_yy;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic             w_cin;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_accept;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_word_gg;
  logic             w_word_gp;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_g;
  logic [WIDTH-1:0] r_s1_p;
  logic [NG-1:0]    r_s1_gg;
  logic [NG-1:0]    r_s1_gp;
  logic             r_s1_cin;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_gg;
  logic             r_gp;

  // Effective operands (subtract is x + ~y + 1) and bit-level generate/propagate
  always_comb begin
    w_yy  = bus.mode ? ~bus.y : bus.y;
    w_cin = bus.mode | bus.carry_in;
    w_g   = bus.x & w_yy;
    w_p   = bus.x ^ w_yy;
  end

  // First lookahead level: generate/propagate of each GROUP-bit group
  always_comb begin : p_group_gp
    logic w_acc_g;
    logic w_acc_p;
    w_gg = '0;
    w_gp = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_acc_g = 1'b0;
      w_acc_p = 1'b1;
      for (int unsigned j = 0; j < GROUP; j++) begin
        w_acc_g = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & w_acc_g);
        w_acc_p = w_acc_p & w_p[k*GROUP+j];
      end
      w_gg[k] = w_acc_g;
      w_gp[k] = w_acc_p;
    end
  end

  // Handshake: S2 frees when empty or drained, S1 frees when empty or moving on
  assign w_s2_adv   = ~r_s2_valid | bus.out_ready;
  assign w_in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Stage 1 register: capture operands' generate/propagate terms on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_g     <= '0;
      r_s1_p     <= '0;
      r_s1_gg    <= '0;
      r_s1_gp    <= '0;
      r_s1_cin   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_g     <= w_g;
      r_s1_p     <= w_p;
      r_s1_gg    <= w_gg;
      r_s1_gp    <= w_gp;
      r_s1_cin   <= w_cin;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Second lookahead level: group carries, intra-group carries from each C[k], sum and flags
  always_comb begin : p_resolve
    logic w_c;
    logic w_cb;
    logic w_cmsb;
    w_sum     = '0;
    w_c       = r_s1_cin;
    w_cmsb    = 1'b0;
    w_word_gg = 1'b0;
    w_word_gp = 1'b1;
    for (int unsigned k = 0; k < NG; k++) begin
      w_cb = w_c;
      for (int unsigned j = 0; j < GROUP; j++) begin
        w_sum[k*GROUP+j] = r_s1_p[k*GROUP+j] ^ w_cb;
        w_cmsb           = w_cb;
        w_cb             = r_s1_g[k*GROUP+j] | (r_s1_p[k*GROUP+j] & w_cb);
      end
      w_c       = r_s1_gg[k] | (r_s1_gp[k] & w_c);
      w_word_gg = r_s1_gg[k] | (r_s1_gp[k] & w_word_gg);
      w_word_gp = w_word_gp & r_s1_gp[k];
    end
    w_cout = w_c;
    w_ovf  = w_c ^ w_cmsb;
  end

  // Stage 2 register: result and flags, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_z         <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_gg        <= 1'b0;
      r_gp        <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_z         <= w_sum;
        r_carry_out <= w_cout;
        r_overflow  <= w_ovf;
        r_gg        <= w_word_gg;
        r_gp        <= w_word_gp;
      end
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = r_s2_valid;
  assign bus.z               = r_z;
  assign bus.carry_out       = r_carry_out;
  assign bus.overflow        = r_overflow;
  assign bus.group_generate  = r_gg;
  assign bus.group_propagate = r_gp;

endmodule

// File: tb/tb_pipelined_carry_lookahead_adder.sv
// Self-checking bench for pipelined_carry_lookahead_adder.
// One 8-bit/4-bit-group instance is used for the directed, stall and reset tests.
// Two 16-bit instances (GROUP=4 and GROUP=16) are used for random streaming.
module tb_pipelined_carry_lookahead_adder;

  typedef struct packed {
    logic [15:0] z;
    logic        co;
    logic        ov;
    logic        gg;
    logic        gp;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_carry_lookahead_adder_if #(.WIDTH(8))  if8 ();
  pipelined_carry_lookahead_adder_if #(.WIDTH(16)) ifa ();
  pipelined_carry_lookahead_adder_if #(.WIDTH(16)) ifb ();

  pipelined_carry_lookahead_adder #(.WIDTH(8),  .GROUP(4))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  pipelined_carry_lookahead_adder #(.WIDTH(16), .GROUP(4))  u_dut16a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pipelined_carry_lookahead_adder #(.WIDTH(16), .GROUP(16)) u_dut16b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q8[$];
  res_t qa[$];
  res_t qb[$];

  // Reference: plain integer arithmetic on w-bit operands
  function automatic res_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic m, input logic cin);
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ux   = longint'(x) & mask;
    longint uy   = longint'(y) & mask;
    longint yy   = m ? (mask - uy) : uy;
    longint c    = (m || cin) ? 1 : 0;
    longint full = ux + yy + c;
    longint sx   = (ux >= half) ? ux - 2 * half : ux;
    longint sy   = (uy >= half) ? uy - 2 * half : uy;
    longint s    = m ? (sx - sy) : (sx + sy + c);
    res_t   r;
    r.z  = 16'(full & mask);
    r.co = (full > mask);
    r.ov = (s >= half) || (s < -half);
    r.gg = ((ux + yy) > mask);
    r.gp = ((ux + yy) == mask);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitors: pop and compare whenever a result is handed over
  always @(negedge clk) begin : mon8
    res_t e;
    res_t a;
    if (rst_n && if8.out_valid && if8.out_ready) begin
      a = {16'(if8.z), if8.carry_out, if8.overflow, if8.group_generate, if8.group_propagate};
      if (q8.size() == 0) fail_now("w8_unexpected", $sformatf("got result 0x%0h, expected none", a));
      else begin
        e = q8.pop_front();
        check("w8_result", 32'(a), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mona
    res_t e;
    res_t a;
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      a = {ifa.z, ifa.carry_out, ifa.overflow, ifa.group_generate, ifa.group_propagate};
      if (qa.size() == 0) fail_now("w16g4_unexpected", $sformatf("got result 0x%0h, expected none", a));
      else begin
        e = qa.pop_front();
        check("w16g4_result", 32'(a), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : monb
    res_t e;
    res_t a;
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      a = {ifb.z, ifb.carry_out, ifb.overflow, ifb.group_generate, ifb.group_propagate};
      if (qb.size() == 0) fail_now("w16g16_unexpected", $sformatf("got result 0x%0h, expected none", a));
      else begin
        e = qb.pop_front();
        check("w16g16_result", 32'(a), 32'(e));
      end
    end
  end

  // Offer one op to the 8-bit instance; returns #1 after the accepting edge
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic m, input logic c);
    bit done;
    done         = 1'b0;
    if8.in_valid = 1'b1;
    if8.x        = x;
    if8.y        = y;
    if8.mode     = m;
    if8.carry_in = c;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (if8.in_ready) begin
        q8.push_back(model(8, 16'(x), 16'(y), m, c));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if8.in_valid = 1'b0;
    if (!done) fail_now("w8_accept_timeout", "op not accepted within 50 cycles");
  endtask

  task automatic drain8(input string name);
    for (int i = 0; i < 30 && q8.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(q8.size()), 32'd0);
  endtask

  task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic m, input logic c);
    ifa.x = x; ifa.y = y; ifa.mode = m; ifa.carry_in = c;
    ifb.x = x; ifb.y = y; ifb.mode = m; ifb.carry_in = c;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [15:0] sx;
    logic [15:0] sy;
    logic        sm;
    logic        sc;
    logic        ra;
    logic        rb;
    int          sent;
    int          cyc;
    res_t        e_a;

    if8.in_valid = 1'b0; if8.out_ready = 1'b1; if8.mode = 1'b0; if8.carry_in = 1'b0;
    if8.x = '0; if8.y = '0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
    drive16('0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_in_ready",  32'(if8.in_ready),  32'd1);
    check("rst_z",         32'(if8.z),         32'd0);
    check("rst_flags",     32'({if8.carry_out, if8.overflow, if8.group_generate, if8.group_propagate}), 32'd0);
    rst_n = 1'b1;

    // First accept on the first edge after release; latency
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    check("lat_one_cycle_after_accept", 32'(if8.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_two_cycles_after_accept", 32'(if8.out_valid), 32'd1);

    // Directed patterns and boundary cases
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    send8(8'h05, 8'h07, 1'b1, 1'b0);
    send8(8'h05, 8'h07, 1'b1, 1'b1);
    send8(8'hF0, 8'h0F, 1'b0, 1'b1);
    send8(8'hFF, 8'h00, 1'b0, 1'b1);
    send8(8'h00, 8'h00, 1'b1, 1'b0);
    send8(8'h80, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      send8(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
    drain8("directed_drain");

    // Backpressure: A, B accepted, C blocked, A held on the output
    if8.out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    e_a = model(8, 16'h0012, 16'h0034, 1'b0, 1'b0);
    send8(8'hA0, 8'h0B, 1'b1, 1'b0);
    if8.in_valid = 1'b1; if8.x = 8'h33; if8.y = 8'h44; if8.mode = 1'b0; if8.carry_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(if8.in_ready),  32'd0);
      check("stall_out_valid", 32'(if8.out_valid), 32'd1);
      check("stall_z_holds_a", 32'(if8.z),         32'(e_a.z[7:0]));
      @(posedge clk);
      #1;
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(if8.in_ready), 32'd1);
    q8.push_back(model(8, 16'h0033, 16'h0044, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_back_to_back", 32'(if8.out_valid), 32'd1);
    end
    @(negedge clk);
    check("drain_done_valid", 32'(if8.out_valid), 32'd0);
    check("drain_done_queue", 32'(q8.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset with two ops in flight
    if8.out_ready = 1'b0;
    send8(8'h11, 8'h22, 1'b0, 1'b0);
    send8(8'h99, 8'h88, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
    check("midrst_in_ready",  32'(if8.in_ready),  32'd1);
    check("midrst_z",         32'(if8.z),         32'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_stale", 32'(if8.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send8(8'hFF, 8'h00, 1'b0, 1'b1);
    drain8("postrst_drain");

    // Streaming at full rate with random out_ready on both 16-bit instances
    sent = 0;
    cyc  = 0;
    sx = 16'hFFFF; sy = 16'h0000; sm = 1'b0; sc = 1'b1;
    drive16(sx, sy, sm, sc);
    ifa.in_valid = 1'b1;
    ifb.in_valid = 1'b1;
    while (sent < 1000 && cyc < 20000) begin
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      ifb.out_ready = ifa.out_ready;
      @(negedge clk);
      ra = ifa.in_ready;
      rb = ifb.in_ready;
      if (ra) qa.push_back(model(16, sx, sy, sm, sc));
      if (rb) qb.push_back(model(16, sx, sy, sm, sc));
      @(posedge clk);
      #1;
      cyc++;
      if (ra || rb) begin
        sent++;
        sx = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
        sy = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom());
        sm = 1'($urandom());
        sc = 1'($urandom());
        drive16(sx, sy, sm, sc);
      end
    end
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    if (sent < 1000) fail_now("stream_timeout", $sformatf("only %0d of 1000 ops accepted", sent));
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("stream_g4_drain",  32'(qa.size()), 32'd0);
    check("stream_g16_drain", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
